// File: rtl/nios_mult_cell_seq.sv
// Iterative DATA_W x DATA_W multiply cell: one SLICE_W-bit slice of src2 per cycle,
// then one signed-correction cycle; returns the low or high product word.
module nios_mult_cell_seq #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] result
);

    localparam int NS     = DATA_W / SLICE_W;
    localparam int IDX_W  = (NS > 1) ? $clog2(NS) : 1;
    localparam int ACC_W  = 2 * DATA_W;
    localparam int PROD_W = DATA_W + SLICE_W;

    generate
        if ((SLICE_W < 1) || (DATA_W % SLICE_W != 0)) begin : g_bad_param
            $error("nios_mult_cell_seq: DATA_W must be a multiple of SLICE_W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_CORR,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_MUL    = 2'b00,
        MODE_MULXUU = 2'b01,
        MODE_MULXSU = 2'b10,
        MODE_MULXSS = 2'b11
    } mode_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_step;
    logic               w_corr;
    logic               w_done;

    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    mode_t              r_mode;
    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_result;
    logic               r_valid;

    logic [SLICE_W-1:0] w_slice;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_term;
    logic               w_sub_b;
    logic               w_sub_a;
    logic [DATA_W-1:0]  w_hi_corr;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_corr       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = S_MUL;
                end
            end
            S_MUL: begin
                w_step = 1'b1;
                if (r_idx == IDX_W'(NS - 1)) w_next_state = S_CORR;
            end
            S_CORR: begin
                w_corr       = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Unsigned partial product of the full A with the current B slice, aligned into the accumulator.
    assign w_slice = r_b[r_idx*SLICE_W +: SLICE_W];
    assign w_prod  = PROD_W'(r_a) * PROD_W'(w_slice);
    assign w_term  = ACC_W'(w_prod) << (r_idx * SLICE_W);

    // Two's-complement fix-up of the unsigned high word for signed operands.
    assign w_sub_b   = r_mode[1] & r_a[DATA_W-1];
    assign w_sub_a   = (r_mode == MODE_MULXSS) & r_b[DATA_W-1];
    assign w_hi_corr = r_acc[ACC_W-1:DATA_W] - (w_sub_b ? r_b : '0) - (w_sub_a ? r_a : '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= MODE_MUL;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_a    <= src1;
                r_b    <= src2;
                r_mode <= mode_t'(mode);
                r_acc  <= '0;
                r_idx  <= '0;
            end else if (w_step) begin
                r_acc <= r_acc + w_term;
                r_idx <= r_idx + IDX_W'(1);
            end else if (w_corr) begin
                r_acc[ACC_W-1:DATA_W] <= w_hi_corr;
            end else if (w_done) begin
                r_result <= (r_mode == MODE_MUL) ? r_acc[DATA_W-1:0] : r_acc[ACC_W-1:DATA_W];
                r_valid  <= 1'b1;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign result_valid = r_valid;
    assign result       = r_result;

endmodule

// File: tb/tb_nios_mult_cell_seq.sv
// Self-checking bench for nios_mult_cell_seq: directed corner cases, handshake, reset abort,
// and randomized regression against a full-product reference model (32- and 64-bit builds).
module tb_nios_mult_cell_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;

    logic        start64;
    logic [1:0]  mode64;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        busy64;
    logic        valid64;
    logic [63:0] result64;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  md;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    always #5 clk = ~clk;

    nios_mult_cell_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .src1(src1), .src2(src2), .busy(busy),
        .result_valid(result_valid), .result(result)
    );

    nios_mult_cell_seq #(.DATA_W(64), .SLICE_W(16)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(start64), .mode(mode64),
        .src1(a64), .src2(b64), .busy(busy64),
        .result_valid(valid64), .result(result64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Full product of the operands extended to their signed/unsigned meaning, then word select.
    function automatic logic [63:0] ref_mul(input int w, input logic [1:0] md,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] mask, ax, bx, p;
        mask = (128'd1 << w) - 128'd1;
        ax   = 128'(a) & mask;
        bx   = 128'(b) & mask;
        if (md[1] && ax[w-1])        ax = ax | ~mask;
        if (md == 2'b11 && bx[w-1])  bx = bx | ~mask;
        p = ax * bx;
        return (md == 2'b00) ? 64'(p & mask) : 64'((p >> w) & mask);
    endfunction

    function automatic logic [63:0] rand_operand(input int w);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 64'd1 << (w - 1);
            3: v = 64'd1;
            default: ;
        endcase
        if (w < 64) v = v & ((64'd1 << w) - 64'd1);
        return v;
    endfunction

    // Called just after an edge with the DUT idle; returns in the result_valid cycle.
    task automatic run32(input logic [1:0] md, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int edges;
        mode = md; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom); src1 = $urandom; src2 = $urandom;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!result_valid && edges < 20);
        check({tag, "_lat"}, 64'(edges), 64'd4);
        check({tag, "_res"}, 64'(result), 64'(exp));
    endtask

    task automatic run64(input logic [1:0] md, input logic [63:0] a, input logic [63:0] b,
                         input string tag);
        int edges;
        mode64 = md; a64 = a; b64 = b; start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0; mode64 = 2'($urandom); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!valid64 && edges < 20);
        check({tag, "_lat"}, 64'(edges), 64'd6);
        check({tag, "_res"}, result64, ref_mul(64, md, a, b));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t q[$];
        op_t op;
        int  last_v;
        logic [1:0]  md;
        logic [31:0] a, b;

        reset_n = 1'b0; start = 1'b0; mode = '0; src1 = '0; src2 = '0;
        start64 = 1'b0; mode64 = '0; a64 = '0; b64 = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("idle_busy",   64'(busy), 64'd0);
            check("idle_valid",  64'(result_valid), 64'd0);
            check("idle_result", 64'(result), 64'd0);
        end
        check("idle_busy64", 64'(busy64), 64'd0);

        run32(2'b00, 32'd7, 32'd6, 32'h0000_002A, "mul_7x6");
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("hold_valid",  64'(result_valid), 64'd0);
            check("hold_result", 64'(result), 64'h2A);
        end
        run32(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, "xuu_2p32");
        run32(2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_2p32");
        run32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ones");
        run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "xuu_ones");
        run32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "xsu_ones");
        run32(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "xss_ones");
        run32(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "xuu_min");
        run32(2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, "xsu_min");
        run32(2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "xss_min");

        // Start held high with operands changing every cycle.
        repeat (2) @(posedge clk);
        #1;
        last_v = -1;
        start  = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (result_valid) begin
                if (q.size() == 0) begin
                    check("burst_spurious", 64'd1, 64'd0);
                end else begin
                    op = q.pop_front();
                    check("burst_res", 64'(result), ref_mul(32, op.md, 64'(op.a), 64'(op.b)));
                end
                if (last_v >= 0) check("burst_gap", 64'(cyc - last_v), 64'd5);
                last_v = cyc;
            end
            if (cyc < 60) begin
                mode = 2'($urandom); src1 = 32'(rand_operand(32)); src2 = 32'(rand_operand(32));
                if (!busy) q.push_back('{md: mode, a: src1, b: src2});
            end else begin
                start = 1'b0;
                if (q.size() == 0) break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("burst_drain", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Reset two cycles into an operation aborts it.
        mode = 2'b01; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("rst_novalid", 64'(result_valid), 64'd0);
            check("rst_nobusy",  64'(busy), 64'd0);
        end
        run32(2'b00, 32'd3, 32'd5, 32'h0000_000F, "after_rst");

        for (int n = 0; n < 200; n++) begin
            md = 2'($urandom);
            a  = 32'(rand_operand(32));
            b  = 32'(rand_operand(32));
            run32(md, a, b, 32'(ref_mul(32, md, 64'(a), 64'(b))), "rand32");
        end

        for (int n = 0; n < 60; n++) begin
            run64(2'($urandom), rand_operand(64), rand_operand(64), "rand64");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
